// File: rtl/jtag_seq.sv
`timescale 1ns/1ps
// jtag_seq: command-driven JTAG TAP sequencer clocked by TCK.
// Accepts TAP-reset / shift-IR / shift-DR / run-idle commands and drives the
// matching TMS/TDI sequence. TDO is captured into a response during shifts.
// Ports:
//   clk        TCK, all flops on posedge
//   reset_b    asynchronous active-low reset
//   cmd_valid / cmd_ready / cmd_op / cmd_len / cmd_data   command handshake
//   tms, tdi   registered TAP drive; tdo  TAP data out
//   rsp_valid / rsp_ready / rsp_data / rsp_err            response handshake
//   busy       high in every state except IDLE
module jtag_seq #(
    parameter int unsigned MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [6:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy
);

    localparam int unsigned CNT_W = 7;
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_DR  = 2'b10;
    localparam logic [1:0] OP_RUN = 2'b11;

    // TAP-reset sequence index runs 1..6; bit 6 is the final tms=0
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(6);
    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_HDR,
        S_SHIFT,
        S_TRL,
        S_RUN,
        S_RSP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               r_tms;
    logic               r_tdi;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic [1:0]         r_op;
    logic [CNT_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data;
    logic               r_init_rsp;

    logic               w_accept;
    logic               w_reject;
    logic [1:0]         w_op;
    logic [CNT_W-1:0]   w_len;
    logic [MAX_LEN-1:0] w_data;
    logic [CNT_W-1:0]   w_len_m1;
    logic               w_tms_nxt;
    logic               w_tdi_nxt;

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, and the TAP drive for the next cycle derived from it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_tms_nxt   = 1'b0;
        w_tdi_nxt   = 1'b0;

        w_accept = (r_state == S_IDLE) && cmd_valid;
        w_op     = w_accept ? cmd_op   : r_op;
        w_len    = w_accept ? cmd_len  : r_len;
        w_data   = w_accept ? cmd_data : r_data;
        w_len_m1 = w_len - CNT_W'(1);

        case (r_state)
            S_INIT: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = r_init_rsp ? S_RSP : S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    case (cmd_op)
                        OP_RST: begin
                            w_state_nxt = S_INIT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                        OP_IR, OP_DR: begin
                            if ((cmd_len == '0) || (cmd_len > MAX_LEN_C)) begin
                                w_state_nxt = S_RSP;
                                w_reject    = 1'b1;
                            end else begin
                                w_state_nxt = S_HDR;
                            end
                        end
                        default: begin
                            w_state_nxt = (cmd_len == '0) ? S_RSP : S_RUN;
                        end
                    endcase
                end
            end
            S_HDR: begin
                if (r_cnt == ((r_op == OP_IR) ? CNT_W'(3) : CNT_W'(2))) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (r_cnt == w_len_m1) begin
                    w_state_nxt = S_TRL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_TRL: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_RSP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (r_cnt == w_len_m1) begin
                    w_state_nxt = S_RSP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase

        // TMS/TDI for the cycle represented by (w_state_nxt, w_cnt_nxt)
        case (w_state_nxt)
            S_INIT:  w_tms_nxt = (w_cnt_nxt != RST_LAST);
            S_HDR:   w_tms_nxt = (w_op == OP_IR) ? (w_cnt_nxt < CNT_W'(2))
                                                 : (w_cnt_nxt == '0);
            S_SHIFT: begin
                w_tms_nxt = (w_cnt_nxt == w_len_m1);
                w_tdi_nxt = w_data[w_cnt_nxt[IDX_W-1:0]];
            end
            S_TRL:   w_tms_nxt = (w_cnt_nxt == '0);
            default: begin
                w_tms_nxt = 1'b0;
                w_tdi_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs, command latch and TDO capture
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_op        <= OP_RST;
            r_len       <= '0;
            r_data      <= '0;
            r_init_rsp  <= 1'b0;
        end else begin
            r_tms       <= w_tms_nxt;
            r_tdi       <= w_tdi_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RSP);
            if (w_accept) begin
                r_op       <= cmd_op;
                r_len      <= cmd_len;
                r_data     <= cmd_data;
                // INIT entered from a command owes a response; after reset it does not
                r_init_rsp <= 1'b1;
                r_rsp_err  <= w_reject;
                r_rsp_data <= '0;
            end else if (r_state == S_SHIFT) begin
                r_rsp_data[r_cnt[IDX_W-1:0]] <= tdo;
            end
        end
    end

    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_jtag_seq.sv
`timescale 1ns/1ps
// tb_jtag_seq: directed bench for jtag_seq with a TAP state model and a
// one-cycle TDI->TDO loopback.
module tb_jtag_seq;

    localparam int unsigned MAX_LEN = 32;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_DR  = 2'b10;
    localparam logic [1:0] OP_RUN = 2'b11;

    localparam logic [3:0] TAP_TLR   = 4'd0;
    localparam logic [3:0] TAP_IDLE  = 4'd1;
    localparam logic [3:0] TAP_SELDR = 4'd2;
    localparam logic [3:0] TAP_CAPDR = 4'd3;
    localparam logic [3:0] TAP_SHDR  = 4'd4;
    localparam logic [3:0] TAP_EX1DR = 4'd5;
    localparam logic [3:0] TAP_PAUDR = 4'd6;
    localparam logic [3:0] TAP_EX2DR = 4'd7;
    localparam logic [3:0] TAP_UPDR  = 4'd8;
    localparam logic [3:0] TAP_SELIR = 4'd9;
    localparam logic [3:0] TAP_CAPIR = 4'd10;
    localparam logic [3:0] TAP_SHIR  = 4'd11;
    localparam logic [3:0] TAP_EX1IR = 4'd12;
    localparam logic [3:0] TAP_PAUIR = 4'd13;
    localparam logic [3:0] TAP_EX2IR = 4'd14;
    localparam logic [3:0] TAP_UPIR  = 4'd15;

    logic               clk = 1'b0;
    logic               reset_b;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [6:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               tms;
    logic               tdi;
    logic               tdo;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic       r_tdo = 1'b0;
    logic [3:0] r_tap = TAP_TLR;

    jtag_seq #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TAP_TLR:   return m ? TAP_TLR   : TAP_IDLE;
            TAP_IDLE:  return m ? TAP_SELDR : TAP_IDLE;
            TAP_SELDR: return m ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: return m ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  return m ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: return m ? TAP_UPDR  : TAP_PAUDR;
            TAP_PAUDR: return m ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: return m ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  return m ? TAP_SELDR : TAP_IDLE;
            TAP_SELIR: return m ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: return m ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  return m ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: return m ? TAP_UPIR  : TAP_PAUIR;
            TAP_PAUIR: return m ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: return m ? TAP_UPIR  : TAP_SHIR;
            default:   return m ? TAP_SELDR : TAP_IDLE;
        endcase
    endfunction

    // TAP model and one-cycle TDI->TDO loopback
    always @(posedge clk) begin
        r_tap <= tap_next(r_tap, tms);
        r_tdo <= tdi;
    end
    assign tdo = r_tdo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle, then scramble the inputs
    task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [MAX_LEN-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_len   = 7'h7f;
        cmd_data  = ~data;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, 64'(rsp_valid), 64'd0);
        check({tag, " cmd_ready back"}, 64'(cmd_ready), 64'd1);
    endtask

    // Send, count cycles after the accept edge until rsp_valid, check response
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [6:0] len,
                           input logic [MAX_LEN-1:0] data, input int exp_n,
                           input logic [MAX_LEN-1:0] exp_data, input logic exp_err);
        int n;
        send(op, len, data);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_n));
        check({tag, " rsp_data"}, 64'(rsp_data), 64'(exp_data));
        check({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
        handshake(tag);
    endtask

    task automatic init_seq(input string tag);
        for (int k = 0; k < 6; k++) begin
            tick();
            check({tag, " init tms"}, 64'(tms), (k < 5) ? 64'd1 : 64'd0);
            check({tag, " init rsp_valid"}, 64'(rsp_valid), 64'd0);
        end
        tick();
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " tap idle"}, 64'(r_tap), 64'(TAP_IDLE));
        check({tag, " no rsp"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [12:0] exp_tms;
        logic [12:0] exp_tdi;
        logic [3:0]  exp_ir [10];

        reset_b   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 7'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst tms", 64'(tms), 64'd1);
        check("rst tdi", 64'(tdi), 64'd0);
        check("rst cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst rsp_err", 64'(rsp_err), 64'd0);
        check("rst rsp_data", 64'(rsp_data), 64'd0);
        check("rst busy", 64'(busy), 64'd1);

        reset_b = 1'b1;
        init_seq("boot");

        // Shift-DR len 8 data A5: tms 1,0,0, 0x7, 1, 1,0; tdi A5 LSB first in shift cycles
        exp_tms = 13'h0C01;
        exp_tdi = 13'h0528;
        send(OP_DR, 7'd8, 32'h0000_00A5);
        for (int k = 0; k < 13; k++) begin
            check("dr8 tms", 64'(tms), 64'(exp_tms[k]));
            check("dr8 tdi", 64'(tdi), 64'(exp_tdi[k]));
            check("dr8 no early rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        check("dr8 rsp_valid", 64'(rsp_valid), 64'd1);
        check("dr8 rsp_data", 64'(rsp_data), 64'h4A);
        check("dr8 rsp_err", 64'(rsp_err), 64'd0);
        check("dr8 cmd_ready low", 64'(cmd_ready), 64'd0);
        handshake("dr8");

        // Shift-IR len 4 data 3 walked through the TAP model
        exp_ir = '{TAP_SELDR, TAP_SELIR, TAP_CAPIR, TAP_SHIR, TAP_SHIR,
                   TAP_SHIR, TAP_SHIR, TAP_EX1IR, TAP_UPIR, TAP_IDLE};
        send(OP_IR, 7'd4, 32'h3);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ir4 tap", 64'(r_tap), 64'(exp_ir[k]));
        end
        check("ir4 rsp_valid", 64'(rsp_valid), 64'd1);
        check("ir4 rsp_data", 64'(rsp_data), 64'h6);
        check("ir4 rsp_err", 64'(rsp_err), 64'd0);
        handshake("ir4");

        // Rejected lengths
        send(OP_DR, 7'd0, 32'hFFFF_FFFF);
        check("rej0 rsp_valid", 64'(rsp_valid), 64'd1);
        check("rej0 rsp_err", 64'(rsp_err), 64'd1);
        check("rej0 rsp_data", 64'(rsp_data), 64'd0);
        check("rej0 tms", 64'(tms), 64'd0);
        handshake("rej0");
        check("rej0 tms after", 64'(tms), 64'd0);
        send(OP_DR, 7'(MAX_LEN + 1), 32'hFFFF_FFFF);
        check("rejmax rsp_valid", 64'(rsp_valid), 64'd1);
        check("rejmax rsp_err", 64'(rsp_err), 64'd1);
        check("rejmax rsp_data", 64'(rsp_data), 64'd0);
        check("rejmax tms", 64'(tms), 64'd0);
        handshake("rejmax");

        // Other commands and length boundaries
        run_cmd("dr32", OP_DR, 7'(MAX_LEN), 32'hFFFF_FFFF, 37, 32'hFFFF_FFFE, 1'b0);
        run_cmd("dr1", OP_DR, 7'd1, 32'h1, 6, 32'h0, 1'b0);
        run_cmd("tapreset", OP_RST, 7'd5, 32'hFFFF_FFFF, 6, 32'h0, 1'b0);
        check("tapreset tap", 64'(r_tap), 64'(TAP_IDLE));
        run_cmd("run3", OP_RUN, 7'd3, 32'hFFFF_FFFF, 3, 32'h0, 1'b0);
        run_cmd("run0", OP_RUN, 7'd0, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);

        // Stalled response: stays stable, blocks a new command
        send(OP_DR, 7'd2, 32'h3);
        repeat (7) tick();
        cmd_valid = 1'b1;
        cmd_op    = OP_RST;
        cmd_len   = 7'd0;
        for (int k = 0; k < 20; k++) begin
            check("stall rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall rsp_data", 64'(rsp_data), 64'h2);
            check("stall cmd_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        cmd_valid = 1'b0;
        handshake("stall");
        check("stall not accepted", 64'(tms), 64'd0);

        // Reset during shift bit 3 of a 16-bit DR
        send(OP_DR, 7'd16, 32'h0000_FFFF);
        repeat (6) tick();
        check("abort pre tdi", 64'(tdi), 64'd1);
        reset_b = 1'b0;
        #1;
        check("abort tms", 64'(tms), 64'd1);
        check("abort tdi", 64'(tdi), 64'd0);
        check("abort rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd1);
        check("abort cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        tick();
        reset_b = 1'b1;
        init_seq("reinit");
        run_cmd("post dr8", OP_DR, 7'd8, 32'h0000_005A, 13, 32'hB4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/jtag_seq.md
JTAG_SEQ -- requirements
Module: jtag_seq

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, the maximum shift length in bits (range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the TCK shared with the TAP; all block flops are posedge.
REQ-003 SHALL have port reset_b, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 TAP-reset, 01 shift-IR, 10 shift-DR, 11 run-idle.
REQ-007 SHALL have port cmd_len, input, 7 bits: shift length in bits, or run-idle cycle count.
REQ-008 SHALL have port cmd_data, input, MAX_LEN bits: TDI payload, LSB shifted first.
REQ-009 SHALL have port tms, output, 1 bit: TAP mode select, registered.
REQ-010 SHALL have port tdi, output, 1 bit: TAP data in, registered.
REQ-011 SHALL have port tdo, input, 1 bit: TAP data out.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: response consumed on a cycle where rsp_valid and rsp_ready are both high.
REQ-014 SHALL have port rsp_data, output, MAX_LEN bits: captured TDO, LSB = first bit shifted.
REQ-015 SHALL have port rsp_err, output, 1 bit: command rejected.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement states INIT, IDLE, HDR, SHIFT, TRL, RUN, RSP.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; IDLE drives tms=0, tdi=0, holding the TAP in Run-Test/Idle.
REQ-019 SHALL, from the cycle after acceptance, drive the TMS sequence one bit per clk, with tms/tdi changing only on posedge clk.
REQ-020 SHALL drive the TAP-reset sequence: tms 1,1,1,1,1,0 (6 cycles).
REQ-021 SHALL drive the shift-DR header as tms 1,0,0 (HDR, 3 cycles).
REQ-022 SHALL drive the shift-IR header as tms 1,1,0,0 (HDR, 4 cycles).
REQ-023 SHALL run SHIFT for cmd_len cycles: tdi=cmd_data[i] on shift cycle i; tms=0 for i<len-1 and tms=1 on i=len-1.
REQ-024 SHALL drive the trailer (TRL) as tms 1,0 (Update, then Idle).
REQ-025 SHALL make the total TAP cycles len+5 for DR and len+6 for IR.
REQ-026 SHALL drive run-idle as tms=0, tdi=0 for cmd_len cycles; len=0 means zero cycles.
REQ-027 SHALL sample tdo on the posedge ending each SHIFT cycle i into rsp_data[i]; rsp_data bits at len and above SHALL be 0.
REQ-028 SHALL use an internal bit counter MAX_LEN-safe (7 bits) with no wrap; the counter is compared against len-1.
REQ-029 SHALL assert rsp_valid the cycle after the last sequence cycle (RSP) and hold rsp_data/rsp_err stable until rsp_ready.
REQ-030 SHALL return to IDLE on the rsp handshake, with cmd_ready high the following cycle.
REQ-031 SHALL set rsp_data=0 in the responses to TAP-reset and run-idle commands.
REQ-032 SHALL reject a shift command with len=0 or len>MAX_LEN: no TAP activity, tms stays 0, rsp_valid next cycle with rsp_err=1 and rsp_data=0.
REQ-033 SHALL accept no new command while rsp_valid is pending, even if rsp_ready is low indefinitely.
REQ-034 SHALL ignore cmd_valid changes after acceptance; cmd_data and cmd_len are latched at acceptance.
REQ-035 SHALL, in INIT, autonomously drive the TAP-reset sequence (REQ-020) with no response generated, then enter IDLE.

Reset
REQ-036 SHALL, while reset_b=0, force state=INIT, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=1, counters=0.
REQ-037 SHALL, on reset_b assertion mid-operation, abort the command immediately and discard any pending response, then perform the REQ-035 sequence after release.

Verification
REQ-038 Reset release -> tms 1,1,1,1,1,0 on the next 6 cycles, then cmd_ready=1, no rsp_valid.
REQ-039 Shift-DR, len=8, data=0xA5, tdo looped from tdi through 1-cycle delay model -> tms 1,0,0,0000000 1,1,0; tdi bits 1,0,1,0,0,1,0,1; rsp_valid at cycle 14 after accept; rsp_err=0.
REQ-040 Shift-IR, len=4, data=0x3, TAP model walking states -> TAP passes Sel-DR, Sel-IR, Cap-IR, Shift-IR, Exit1-IR, Update-IR, Idle; total 10 cycles.
REQ-041 Shift-DR len=0 and len=MAX_LEN+1 -> rsp_err=1 the next cycle, tms constant 0.
REQ-042 rsp_ready held low 20 cycles after a response -> rsp_valid and rsp_data stable, cmd_ready=0 throughout, and a new cmd_valid is not accepted.
REQ-043 reset_b pulsed low during SHIFT bit 3 of len=16 -> tms=1 immediately, no response, re-init sequence after release, next command executes normally.
